bus_activity_timers: RTL and testbench

BUS_ACTIVITY_TIMERS -- requirements
Module: bus_activity_timers

---
 rtl/i3c_pkg.sv | 14 +
 rtl/bus_activity_timers_sat_counter.sv | 24 ++
 rtl/bus_activity_timers.sv | 106 ++++++++++
 tb/tb_bus_activity_timers.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared I3C definitions: bus activity FSM states and timer indices.
package i3c_pkg;

    typedef enum logic {
        BUSY  = 1'b0,
        COUNT = 1'b1
    } bus_act_state_e;

    localparam int unsigned NumTimers = 3;
    localparam int unsigned IdxFree   = 0;
    localparam int unsigned IdxAvail  = 1;
    localparam int unsigned IdxIdle   = 2;

endpackage

// File: rtl/bus_activity_timers_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
    parameter int unsigned Width = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + One;
        end
    end

endmodule

// File: rtl/bus_activity_timers.sv
// Bus free / available / idle timers: counts cycles since STOP (or enable rise)
// and raises sticky threshold flags plus one-cycle rise pulses.
module bus_activity_timers
    import i3c_pkg::*;
#(
    parameter int unsigned CntWidth = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                start_det_i,
    input  logic                stop_det_i,
    input  logic [CntWidth-1:0] t_bus_free_i,
    input  logic [CntWidth-1:0] t_bus_available_i,
    input  logic [CntWidth-1:0] t_bus_idle_i,
    output logic                bus_busy_o,
    output logic                bus_free_o,
    output logic                bus_available_o,
    output logic                bus_idle_o,
    output logic                bus_free_det_o,
    output logic                bus_available_det_o,
    output logic                bus_idle_det_o
);

    bus_act_state_e        state;
    logic                  en_q;
    logic [CntWidth-1:0]   count;
    logic [NumTimers-1:0]  flags;
    logic [NumTimers-1:0]  dets;
    logic [NumTimers-1:0]  reached;
    logic                  leave_count;
    logic                  enter_count;
    logic                  clr_cnt;
    logic                  inc_cnt;

    assign leave_count = start_det_i | ~enable_i;
    assign enter_count = enable_i & ~start_det_i & (stop_det_i | ~en_q);

    // Counter is held at zero throughout BUSY, so the entry edge loads 0 as well.
    assign clr_cnt = (state == BUSY) | leave_count | stop_det_i;
    assign inc_cnt = (state == COUNT);

    always_comb begin
        reached            = '0;
        reached[IdxFree]   = (count >= t_bus_free_i);
        reached[IdxAvail]  = (count >= t_bus_available_i);
        reached[IdxIdle]   = (count >= t_bus_idle_i);
    end

    sat_counter #(
        .Width (CntWidth)
    ) u_counter (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (clr_cnt),
        .inc   (inc_cnt),
        .count (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BUSY;
            en_q  <= 1'b0;
            flags <= '0;
            dets  <= '0;
        end else begin
            en_q <= enable_i;
            case (state)
                BUSY: begin
                    flags <= '0;
                    dets  <= '0;
                    if (enter_count) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (leave_count) begin
                        state <= BUSY;
                        flags <= '0;
                        dets  <= '0;
                    end else if (stop_det_i) begin
                        flags <= '0;
                        dets  <= '0;
                    end else begin
                        flags <= flags | reached;
                        dets  <= reached & ~flags;
                    end
                end
                default: begin
                    state <= BUSY;
                    flags <= '0;
                    dets  <= '0;
                end
            endcase
        end
    end

    assign bus_busy_o          = (state == BUSY);
    assign bus_free_o          = flags[IdxFree];
    assign bus_available_o     = flags[IdxAvail];
    assign bus_idle_o          = flags[IdxIdle];
    assign bus_free_det_o      = dets[IdxFree];
    assign bus_available_det_o = dets[IdxAvail];
    assign bus_idle_det_o      = dets[IdxIdle];

endmodule

// File: tb/tb_bus_activity_timers.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-count model.
module tb_bus_activity_timers;

    localparam int unsigned W  = 20;
    localparam int unsigned W4 = 4;

    logic clk = 1'b0;
    logic rst, enable, start_det, stop_det;
    logic [W-1:0]  t_free, t_avail, t_idle;
    logic [W4-1:0] t4_free, t4_avail, t4_idle;

    logic busy20, free20, avail20, idle20, fdet20, adet20, idet20;
    logic busy4, free4, avail4, idle4, fdet4, adet4, idet4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_activity_timers #(.CntWidth(W)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .start_det_i(start_det), .stop_det_i(stop_det),
        .t_bus_free_i(t_free), .t_bus_available_i(t_avail), .t_bus_idle_i(t_idle),
        .bus_busy_o(busy20), .bus_free_o(free20), .bus_available_o(avail20),
        .bus_idle_o(idle20), .bus_free_det_o(fdet20),
        .bus_available_det_o(adet20), .bus_idle_det_o(idet20)
    );

    bus_activity_timers #(.CntWidth(W4)) dut4 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .start_det_i(start_det), .stop_det_i(stop_det),
        .t_bus_free_i(t4_free), .t_bus_available_i(t4_avail), .t_bus_idle_i(t4_idle),
        .bus_busy_o(busy4), .bus_free_o(free4), .bus_available_o(avail4),
        .bus_idle_o(idle4), .bus_free_det_o(fdet4),
        .bus_available_det_o(adet4), .bus_idle_det_o(idet4)
    );

    // Model: "elapsed" is the number of cycles spent counting since entry or STOP.
    typedef struct {
        bit          busy;
        int unsigned elapsed;
        bit [2:0]    flags;
        bit [2:0]    det;
        bit          prev_en;
    } model_t;

    model_t m20, m4;

    function automatic model_t model_reset();
        model_t r;
        r.busy = 1'b1; r.elapsed = 0; r.flags = '0; r.det = '0; r.prev_en = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, bit en, bit st, bit sp,
                                          int unsigned thr_f, int unsigned thr_a,
                                          int unsigned thr_i, int unsigned cmax);
        model_t n;
        int unsigned thr[3];
        int unsigned cv;
        n = m;
        thr = '{thr_f, thr_a, thr_i};
        n.det = '0;
        if (!m.busy) begin
            if (st || !en) begin
                n.busy = 1'b1; n.elapsed = 0; n.flags = '0;
            end else if (sp) begin
                n.elapsed = 0; n.flags = '0;
            end else begin
                cv = (m.elapsed > cmax) ? cmax : m.elapsed;
                for (int i = 0; i < 3; i++) if (cv >= thr[i]) n.flags[i] = 1'b1;
                n.det = n.flags & ~m.flags;
                n.elapsed = m.elapsed + 1;
            end
        end else if (en && !st && (sp || !m.prev_en)) begin
            n.busy = 1'b0; n.elapsed = 0;
        end
        n.prev_en = en;
        return n;
    endfunction

    function automatic logic [6:0] model_out(model_t m);
        return {m.busy, m.flags[0], m.flags[1], m.flags[2], m.det[0], m.det[1], m.det[2]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m20 <= model_reset();
            m4  <= model_reset();
        end else begin
            m20 <= model_step(m20, enable, start_det, stop_det, t_free, t_avail, t_idle, (1 << W) - 1);
            m4  <= model_step(m4, enable, start_det, stop_det, t4_free, t4_avail, t4_idle, (1 << W4) - 1);
        end
    end

    logic [6:0] obs20, obs4, exp20, exp4;
    assign obs20 = {busy20, free20, avail20, idle20, fdet20, adet20, idet20};
    assign obs4  = {busy4, free4, avail4, idle4, fdet4, adet4, idet4};
    assign exp20 = model_out(m20);
    assign exp4  = model_out(m4);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; start_det = 1'b0; stop_det = 1'b0;
        t_free = '0; t_avail = '0; t_idle = '0;
        t4_free = '0; t4_avail = '0; t4_idle = '0;
        tick(); tick();
        checks++;
        if (obs20 !== 7'b1000000 || obs4 !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_state got20=%b got4=%b want=1000000", obs20, obs4);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs20 !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_release got=%b want=1000000", obs20);
        end
    endtask

    task automatic test_free_basic();
        t_free = 3; t_avail = 100; t_idle = 100;
        t4_free = 15; t4_avail = 15; t4_idle = 15;
        enable = 1'b1; stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        checks++;
        if (busy20 !== 1'b0) begin
            errors++;
            $display("FAIL free_busy_fall got=%b want=0", busy20);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (free20 !== (e >= 4) || fdet20 !== (e == 4)) begin
                errors++;
                $display("FAIL free_edge%0d got free=%b det=%b want free=%b det=%b",
                         e, free20, fdet20, e >= 4, e == 4);
            end
            checks++;
            if (obs20 !== exp20 || obs4 !== exp4) begin
                errors++;
                $display("FAIL free_model edge%0d got=%b/%b want=%b/%b", e, obs20, obs4, exp20, exp4);
            end
        end
    endtask

    task automatic test_thresholds();
        t_free = 5; t_avail = 10; t_idle = 20;
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            checks++;
            if (obs20 !== exp20 || obs4 !== exp4) begin
                errors++;
                $display("FAIL thr_model edge%0d got=%b/%b want=%b/%b", e, obs20, obs4, exp20, exp4);
            end
        end
        checks++;
        if ({free20, avail20, idle20} !== 3'b110) begin
            errors++;
            $display("FAIL thr_flags_edge11 got=%b want=110", {free20, avail20, idle20});
        end
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
        checks++;
        if (obs20 !== 7'b1000000) begin
            errors++;
            $display("FAIL thr_start_clear got=%b want=1000000", obs20);
        end
        for (int e = 0; e < 25; e++) begin
            tick();
            checks++;
            if (obs20 !== 7'b1000000 || obs20 !== exp20) begin
                errors++;
                $display("FAIL thr_stay_busy cyc%0d got=%b want=1000000", e, obs20);
            end
        end
    endtask

    task automatic test_start_stop_same();
        t_free = 0; t_avail = 0; t_idle = 0;
        t4_free = 0; t4_avail = 0; t4_idle = 0;
        start_det = 1'b1; stop_det = 1'b1;
        tick();
        start_det = 1'b0; stop_det = 1'b0;
        for (int e = 0; e < 20; e++) begin
            checks++;
            if (obs20 !== 7'b1000000 || obs4 !== 7'b1000000) begin
                errors++;
                $display("FAIL same_edge cyc%0d got=%b/%b want=1000000", e, obs20, obs4);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        int unsigned want;
        t4_free = 15; t4_avail = 15; t4_idle = 15;
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        for (int unsigned k = 1; k <= 40; k++) begin
            tick();
            want = (k > 15) ? 15 : k;
            checks++;
            if (dut4.u_counter.count !== 4'(want)) begin
                errors++;
                $display("FAIL sat_count k=%0d got=%0d want=%0d", k, dut4.u_counter.count, want);
            end
            checks++;
            if ({free4, avail4, idle4} !== ((k >= 16) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL sat_flags k=%0d got=%b want=%b", k, {free4, avail4, idle4},
                         (k >= 16) ? 3'b111 : 3'b000);
            end
            if (obs20 !== exp20 || obs4 !== exp4) begin
                errors++;
                $display("FAIL sat_model k=%0d got=%b/%b want=%b/%b", k, obs20, obs4, exp20, exp4);
            end
        end
    endtask

    task automatic test_enable_toggle();
        enable = 1'b0;
        tick(); tick();
        t_free = 50; t_avail = 50; t_idle = 0;
        enable = 1'b1;
        tick();
        checks++;
        if (busy20 !== 1'b0 || idle20 !== 1'b0) begin
            errors++;
            $display("FAIL en_entry got busy=%b idle=%b want busy=0 idle=0", busy20, idle20);
        end
        tick();
        checks++;
        if (idle20 !== 1'b1 || idet20 !== 1'b1) begin
            errors++;
            $display("FAIL en_idle got idle=%b det=%b want 1 1", idle20, idet20);
        end
        tick(); tick();
        checks++;
        if (obs20 !== exp20 || obs4 !== exp4) begin
            errors++;
            $display("FAIL en_model got=%b/%b want=%b/%b", obs20, obs4, exp20, exp4);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (obs20 !== 7'b1000000 || obs4 !== 7'b1000000) begin
            errors++;
            $display("FAIL en_drop got=%b/%b want=1000000", obs20, obs4);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; t_free = 20; t_avail = 100; t_idle = 100;
        t4_free = 2; t4_avail = 3; t4_idle = 4;
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        #2 rst = 1'b1; enable = 1'b0;
        #1;
        checks++;
        if (obs20 !== 7'b1000000 || obs4 !== 7'b1000000) begin
            errors++;
            $display("FAIL rst_async got=%b/%b want=1000000", obs20, obs4);
        end
        tick(); tick();
        rst = 1'b0;
        for (int e = 0; e < 25; e++) begin
            tick();
            checks++;
            if (obs20 !== 7'b1000000 || obs4 !== 7'b1000000) begin
                errors++;
                $display("FAIL rst_quiet cyc%0d got=%b/%b want=1000000", e, obs20, obs4);
            end
        end
        enable = 1'b1; stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            checks++;
            if (free20 !== (k >= 21) || obs20 !== exp20 || obs4 !== exp4) begin
                errors++;
                $display("FAIL rst_resume k=%0d got=%b/%b want=%b/%b free_want=%b",
                         k, obs20, obs4, exp20, exp4, k >= 21);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            start_det = ($urandom_range(0, 99) < 4);
            stop_det  = ($urandom_range(0, 99) < 6);
            enable    = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 49) == 0) begin
                t_free   = W'($urandom_range(0, 25));
                t_avail  = W'($urandom_range(0, 25));
                t_idle   = W'($urandom_range(0, 25));
                t4_free  = W4'($urandom_range(0, 15));
                t4_avail = W4'($urandom_range(0, 15));
                t4_idle  = W4'($urandom_range(0, 15));
            end
            tick();
            checks++;
            if (obs20 !== exp20 || obs4 !== exp4) begin
                errors++;
                $display("FAIL random cyc%0d got=%b/%b want=%b/%b", c, obs20, obs4, exp20, exp4);
            end
        end
        rst = 1'b0; start_det = 1'b0; stop_det = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_basic();
        test_thresholds();
        test_start_stop_same();
        test_saturate();
        test_enable_toggle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
